// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/stall unit.
package hazard_pkg;

  // Stall controller state.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } hazState_e;

  // Number of bubbles a detected hazard requires.
  localparam logic [1:0] BUBBLE_NONE = 2'd0;
  localparam logic [1:0] BUBBLE_ONE  = 2'd1;
  localparam logic [1:0] BUBBLE_TWO  = 2'd2;

  // Architectural zero register; writes to it never create a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : hazard_pkg

// File: rtl/hazard_dep_cmp.sv
// Single register dependency comparator: flags a match when the source is
// actually read, the enable condition holds and the destination is a real
// (non-zero) register equal to the source.
module hazard_dep_cmp
  import hazard_pkg::*;
#(
  parameter logic [4:0] REG_ZERO = hazard_pkg::REG_ZERO
) (
  input  logic [4:0] src,
  input  logic       uses,
  input  logic [4:0] dst,
  input  logic       en,
  output logic       match
);

  // Pure combinational compare; no state.
  always_comb begin
    match = en && uses && (src == dst) && (dst != REG_ZERO);
  end

endmodule : hazard_dep_cmp

// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall control for the 5-stage pipeline. Detects RAW
// hazards that forwarding cannot resolve, derives the bubble count, and runs a
// small RUN/STALL/HALT controller that gates PC, IF/ID and ID/EX.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int         PERF_W   = 32,
  parameter logic [4:0] REG_ZERO = hazard_pkg::REG_ZERO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ID_RS,
  input  logic [4:0]        ID_RT,
  input  logic              ID_UsesRS,
  input  logic              ID_UsesRT,
  input  logic              ID_Branch,
  input  logic              ID_BranchTaken,
  input  logic              ID_Jump,
  input  logic              ID_Halt,
  input  logic              ID_EX_RegWrite,
  input  logic              ID_EX_MemRead,
  input  logic [4:0]        ID_EX_WriteReg,
  input  logic              EX_MEM_MemRead,
  input  logic [4:0]        EX_MEM_WriteReg,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
  output logic              Halted,
  output logic [PERF_W-1:0] Stall_Cycles
);

  hazState_e   state_r;
  logic [1:0]  cnt_r;
  logic [1:0]  bubbleN_s;

  // jr reads RS in ID just like a branch, so it shares the branch RS path.
  logic branchRs_s;
  logic branchRt_s;
  logic aluEnRs_s, aluEnRt_s, memEnRs_s, memEnRt_s;
  logic loadExRs_s, loadExRt_s, aluRs_s, aluRt_s, memRs_s, memRt_s;
  logic countEn_s;

  // Enables for the comparator instances.
  always_comb begin
    branchRs_s = ID_Branch || (ID_Jump && ID_UsesRS);
    branchRt_s = ID_Branch;
    aluEnRs_s  = branchRs_s && ID_EX_RegWrite && !ID_EX_MemRead;
    aluEnRt_s  = branchRt_s && ID_EX_RegWrite && !ID_EX_MemRead;
    memEnRs_s  = branchRs_s && EX_MEM_MemRead;
    memEnRt_s  = branchRt_s && EX_MEM_MemRead;
  end

  hazard_dep_cmp #(.REG_ZERO(REG_ZERO)) uLoadExRs (.src(ID_RS), .uses(ID_UsesRS), .dst(ID_EX_WriteReg),  .en(ID_EX_MemRead), .match(loadExRs_s));
  hazard_dep_cmp #(.REG_ZERO(REG_ZERO)) uLoadExRt (.src(ID_RT), .uses(ID_UsesRT), .dst(ID_EX_WriteReg),  .en(ID_EX_MemRead), .match(loadExRt_s));
  hazard_dep_cmp #(.REG_ZERO(REG_ZERO)) uAluRs    (.src(ID_RS), .uses(ID_UsesRS), .dst(ID_EX_WriteReg),  .en(aluEnRs_s),     .match(aluRs_s));
  hazard_dep_cmp #(.REG_ZERO(REG_ZERO)) uAluRt    (.src(ID_RT), .uses(ID_UsesRT), .dst(ID_EX_WriteReg),  .en(aluEnRt_s),     .match(aluRt_s));
  hazard_dep_cmp #(.REG_ZERO(REG_ZERO)) uMemRs    (.src(ID_RS), .uses(ID_UsesRS), .dst(EX_MEM_WriteReg), .en(memEnRs_s),     .match(memRs_s));
  hazard_dep_cmp #(.REG_ZERO(REG_ZERO)) uMemRt    (.src(ID_RT), .uses(ID_UsesRT), .dst(EX_MEM_WriteReg), .en(memEnRt_s),     .match(memRt_s));

  // Bubble count = max over matching hazard terms; branch-on-load in EX wins.
  always_comb begin
    bubbleN_s = BUBBLE_NONE;
    if ((branchRs_s && loadExRs_s) || (branchRt_s && loadExRt_s)) begin
      bubbleN_s = BUBBLE_TWO;
    end else if (loadExRs_s || loadExRt_s || aluRs_s || aluRt_s || memRs_s || memRt_s) begin
      bubbleN_s = BUBBLE_ONE;
    end else begin
      bubbleN_s = BUBBLE_NONE;
    end
  end

  // Output decode; reset forces the frozen/bubble pattern immediately.
  always_comb begin
    PC_Write    = 1'b0;
    IF_ID_Write = 1'b0;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b1;
    if (rst) begin
      ID_EX_Flush = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (bubbleN_s == BUBBLE_NONE) begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
            IF_ID_Flush = ID_Jump || (ID_Branch && ID_BranchTaken);
            ID_EX_Flush = 1'b0;
          end else begin
            ID_EX_Flush = 1'b1;
          end
        end
        STALL:   ID_EX_Flush = 1'b1;
        HALT:    ID_EX_Flush = 1'b1;
        default: ID_EX_Flush = 1'b1;
      endcase
    end
  end

  // Controller state, remaining-stall counter and halt latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= 2'd0;
      Halted  <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (bubbleN_s == BUBBLE_TWO) begin
            cnt_r   <= 2'd1;
            state_r <= STALL;
          end else if ((bubbleN_s == BUBBLE_NONE) && ID_Halt) begin
            state_r <= HALT;
            Halted  <= 1'b1;
          end
        end
        STALL: begin
          cnt_r <= cnt_r - 2'd1;
          // A corrupted zero count also returns to RUN rather than wrapping.
          if (cnt_r <= 2'd1) begin
            state_r <= RUN;
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= 2'd0;
        end
      endcase
    end
  end

  // Bubble cycles caused by hazards (halt bubbles excluded).
  always_comb begin
    countEn_s = ID_EX_Flush && ((state_r == RUN) || (state_r == STALL));
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Stall_Cycles <= {PERF_W{1'b0}};
    end else if (countEn_s && (Stall_Cycles != {PERF_W{1'b1}})) begin
      Stall_Cycles <= Stall_Cycles + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      Stall_Cycles <= Stall_Cycles;
    end
  end

endmodule : hazard_stall_unit

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit. A narrow perf counter
// is used so saturation is reachable in a short run.
module tb_hazard_stall_unit;

  localparam int PERF_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        ID_RS, ID_RT;
  logic              ID_UsesRS, ID_UsesRT;
  logic              ID_Branch, ID_BranchTaken, ID_Jump, ID_Halt;
  logic              ID_EX_RegWrite, ID_EX_MemRead;
  logic [4:0]        ID_EX_WriteReg;
  logic              EX_MEM_MemRead;
  logic [4:0]        EX_MEM_WriteReg;
  logic              PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Halted;
  logic [PERF_W-1:0] Stall_Cycles;
  logic [3:0]        ctl;

  int checks = 0;
  int fails  = 0;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}
  localparam logic [3:0] CTL_RUN   = 4'b1100;
  localparam logic [3:0] CTL_BUB   = 4'b0001;
  localparam logic [3:0] CTL_FLUSH = 4'b1110;

  assign ctl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush};

  always #5 clk = ~clk;

  hazard_stall_unit #(.PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst),
    .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_UsesRS(ID_UsesRS), .ID_UsesRT(ID_UsesRT),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump), .ID_Halt(ID_Halt),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_WriteReg(ID_EX_WriteReg),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_WriteReg(EX_MEM_WriteReg),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .Halted(Halted), .Stall_Cycles(Stall_Cycles)
  );

  task automatic clear_inputs();
    ID_RS = 5'd0; ID_RT = 5'd0; ID_UsesRS = 1'b0; ID_UsesRT = 1'b0;
    ID_Branch = 1'b0; ID_BranchTaken = 1'b0; ID_Jump = 1'b0; ID_Halt = 1'b0;
    ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_WriteReg = 5'd0;
    EX_MEM_MemRead = 1'b0; EX_MEM_WriteReg = 5'd0;
  endtask

  // ID holds add $3,$rs,$rt style instruction reading both sources
  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt);
    ID_RS = rs; ID_RT = rt; ID_UsesRS = 1'b1; ID_UsesRT = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    checks++; if (ctl !== CTL_BUB) begin fails++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_BUB); end
    checks++; if (Halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", Halted); end
    checks++; if (Stall_Cycles !== 4'd0) begin fails++; $display("FAIL reset_cycles: got %0d expected 0", Stall_Cycles); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL reset_release_ctl: got %b expected %b", ctl, CTL_RUN); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_WriteReg = 5'd2;
    set_id(5'd2, 5'd4);
    #1;
    checks++; if (ctl !== CTL_BUB) begin fails++; $display("FAIL load_use_stall: got %b expected %b", ctl, CTL_BUB); end
    @(negedge clk);
    clear_inputs();
    EX_MEM_MemRead = 1'b1; EX_MEM_WriteReg = 5'd2;
    set_id(5'd2, 5'd4);
    #1;
    checks++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL load_use_resume: got %b expected %b", ctl, CTL_RUN); end
    checks++; if (Stall_Cycles !== 4'd1) begin fails++; $display("FAIL load_use_cycles: got %0d expected 1", Stall_Cycles); end
  endtask

  task automatic test_branch_load_ex();
    @(negedge clk);
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_WriteReg = 5'd2;
    set_id(5'd2, 5'd5); ID_Branch = 1'b1; ID_BranchTaken = 1'b1;
    #1;
    checks++; if (ctl !== CTL_BUB) begin fails++; $display("FAIL brload_first: got %b expected %b", ctl, CTL_BUB); end
    @(negedge clk);
    ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_WriteReg = 5'd0;
    EX_MEM_MemRead = 1'b1; EX_MEM_WriteReg = 5'd2;
    #1;
    checks++; if (ctl !== CTL_BUB) begin fails++; $display("FAIL brload_second: got %b expected %b", ctl, CTL_BUB); end
    @(negedge clk);
    EX_MEM_MemRead = 1'b0; EX_MEM_WriteReg = 5'd0;
    #1;
    checks++; if (ctl !== CTL_FLUSH) begin fails++; $display("FAIL brload_taken_flush: got %b expected %b", ctl, CTL_FLUSH); end
    checks++; if (Stall_Cycles !== 4'd3) begin fails++; $display("FAIL brload_cycles: got %0d expected 3", Stall_Cycles); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL brload_flush_once: got %b expected %b", ctl, CTL_RUN); end
  endtask

  task automatic test_branch_alu_mem();
    @(negedge clk);
    clear_inputs();
    ID_EX_RegWrite = 1'b1; ID_EX_WriteReg = 5'd2;
    set_id(5'd2, 5'd0); ID_Branch = 1'b1;
    #1;
    checks++; if (ctl !== CTL_BUB) begin fails++; $display("FAIL br_alu_stall: got %b expected %b", ctl, CTL_BUB); end
    @(negedge clk);
    clear_inputs();
    EX_MEM_MemRead = 1'b1; EX_MEM_WriteReg = 5'd2;
    set_id(5'd7, 5'd2); ID_Branch = 1'b1;
    #1;
    checks++; if (ctl !== CTL_BUB) begin fails++; $display("FAIL br_mem_stall: got %b expected %b", ctl, CTL_BUB); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (Stall_Cycles !== 4'd5) begin fails++; $display("FAIL br_alu_mem_cycles: got %0d expected 5", Stall_Cycles); end
    // ALU result in EX feeding a non-branch is forwarded, no stall
    ID_EX_RegWrite = 1'b1; ID_EX_WriteReg = 5'd2; set_id(5'd2, 5'd3);
    #1;
    checks++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL alu_nonbranch: got %b expected %b", ctl, CTL_RUN); end
    // jr $2 behind add $2 stalls
    clear_inputs();
    ID_EX_RegWrite = 1'b1; ID_EX_WriteReg = 5'd2;
    ID_Jump = 1'b1; ID_UsesRS = 1'b1; ID_RS = 5'd2;
    #1;
    checks++; if (ctl !== CTL_BUB) begin fails++; $display("FAIL jr_alu_stall: got %b expected %b", ctl, CTL_BUB); end
    @(negedge clk);
    clear_inputs();
    #1;
  endtask

  task automatic test_no_stall();
    @(negedge clk);
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_WriteReg = 5'd0;
    set_id(5'd0, 5'd4);
    #1;
    checks++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL zero_reg_nostall: got %b expected %b", ctl, CTL_RUN); end
    ID_EX_WriteReg = 5'd2; ID_RS = 5'd1; ID_RT = 5'd2; ID_UsesRT = 1'b0;
    #1;
    checks++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL unused_rt_nostall: got %b expected %b", ctl, CTL_RUN); end
    clear_inputs();
    ID_Jump = 1'b1;
    #1;
    checks++; if (ctl !== CTL_FLUSH) begin fails++; $display("FAIL jump_flush: got %b expected %b", ctl, CTL_FLUSH); end
    ID_Jump = 1'b0; ID_Branch = 1'b1; ID_BranchTaken = 1'b0;
    #1;
    checks++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL branch_not_taken: got %b expected %b", ctl, CTL_RUN); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (Stall_Cycles !== 4'd6) begin fails++; $display("FAIL no_stall_cycles: got %0d expected 6", Stall_Cycles); end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_WriteReg = 5'd2;
    set_id(5'd2, 5'd5); ID_Branch = 1'b1;
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1;
    checks++; if (ctl !== CTL_BUB) begin fails++; $display("FAIL rst_stall_ctl: got %b expected %b", ctl, CTL_BUB); end
    checks++; if (Stall_Cycles !== 4'd0) begin fails++; $display("FAIL rst_stall_cycles: got %0d expected 0", Stall_Cycles); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL rst_stall_run: got %b expected %b", ctl, CTL_RUN); end
    @(posedge clk); #1;
    checks++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL rst_stall_run2: got %b expected %b", ctl, CTL_RUN); end
    checks++; if (Stall_Cycles !== 4'd0) begin fails++; $display("FAIL rst_stall_cycles2: got %0d expected 0", Stall_Cycles); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_WriteReg = 5'd9;
    set_id(5'd9, 5'd1);
    repeat (15) @(posedge clk);
    #1;
    checks++; if (Stall_Cycles !== 4'd15) begin fails++; $display("FAIL sat_reach: got %0d expected 15", Stall_Cycles); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (Stall_Cycles !== 4'd15) begin fails++; $display("FAIL sat_hold: got %0d expected 15", Stall_Cycles); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_halt();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_WriteReg = 5'd2;
    set_id(5'd2, 5'd5); ID_Branch = 1'b1; ID_Halt = 1'b1;
    #1;
    checks++; if (ctl !== CTL_BUB) begin fails++; $display("FAIL halt_pending_ctl: got %b expected %b", ctl, CTL_BUB); end
    @(posedge clk); #1;
    checks++; if (Halted !== 1'b0) begin fails++; $display("FAIL halt_deferred: got %b expected 0", Halted); end
    @(negedge clk);
    ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_WriteReg = 5'd0;
    EX_MEM_MemRead = 1'b1; EX_MEM_WriteReg = 5'd2;
    @(negedge clk);
    EX_MEM_MemRead = 1'b0; EX_MEM_WriteReg = 5'd0;
    #1;
    checks++; if (Halted !== 1'b0) begin fails++; $display("FAIL halt_after_stall_pre: got %b expected 0", Halted); end
    checks++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL halt_run_cycle: got %b expected %b", ctl, CTL_RUN); end
    @(posedge clk); #1;
    checks++; if (Halted !== 1'b1) begin fails++; $display("FAIL halt_latched: got %b expected 1", Halted); end
    ID_Halt = 1'b0; ID_Jump = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (ctl !== CTL_BUB) begin fails++; $display("FAIL halt_hold_%0d: got %b expected %b", i, ctl, CTL_BUB); end
    end
    checks++; if (Stall_Cycles !== 4'd2) begin fails++; $display("FAIL halt_cycles: got %0d expected 2", Stall_Cycles); end
    checks++; if (Halted !== 1'b1) begin fails++; $display("FAIL halt_absorbing: got %b expected 1", Halted); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load_ex();
    test_branch_alu_mem();
    test_no_stall();
    test_reset_mid_stall();
    test_saturate();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_hazard_stall_unit
